// File: rtl/lda_pkg.sv
// Shared types and register addresses for the line-draw Avalon-MM slave.
package lda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_MODE   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_GO     = 3'd2;
  localparam logic [2:0] ADDR_START  = 3'd3;
  localparam logic [2:0] ADDR_END    = 3'd4;
  localparam logic [2:0] ADDR_COLOR  = 3'd5;

  localparam int unsigned PT_XW = 9;
  localparam int unsigned PT_YW = 8;

  // Matches the START/END register layout: y above x.
  typedef struct packed {
    logic [PT_YW-1:0] y;
    logic [PT_XW-1:0] x;
  } point_t;

endpackage

// File: rtl/lda_cmd_regs.sv
// Shadow/active command registers: CPU writes land in the shadow copy,
// the whole set is copied to the active copy on latch.
module lda_cmd_regs
  import lda_pkg::*;
#(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8,
  parameter int unsigned CW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_start,
  input  logic             wr_end,
  input  logic             wr_color,
  input  logic [XW+YW-1:0] wdata,
  input  logic             latch,
  output logic [XW+YW-1:0] shd_start,
  output logic [XW+YW-1:0] shd_end,
  output logic [CW-1:0]    shd_color,
  output logic [XW+YW-1:0] act_start,
  output logic [XW+YW-1:0] act_end,
  output logic [CW-1:0]    act_color
);

  logic [XW+YW-1:0] shd_start_q, shd_start_d;
  logic [XW+YW-1:0] shd_end_q,   shd_end_d;
  logic [CW-1:0]    shd_color_q, shd_color_d;
  logic [XW+YW-1:0] act_start_q, act_start_d;
  logic [XW+YW-1:0] act_end_q,   act_end_d;
  logic [CW-1:0]    act_color_q, act_color_d;

  always_comb begin
    shd_start_d = wr_start ? wdata : shd_start_q;
    shd_end_d   = wr_end   ? wdata : shd_end_q;
    shd_color_d = wr_color ? wdata[CW-1:0] : shd_color_q;
    act_start_d = latch ? shd_start_q : act_start_q;
    act_end_d   = latch ? shd_end_q   : act_end_q;
    act_color_d = latch ? shd_color_q : act_color_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_start_q <= '0;
      shd_end_q   <= '0;
      shd_color_q <= '0;
      act_start_q <= '0;
      act_end_q   <= '0;
      act_color_q <= '0;
    end else begin
      shd_start_q <= shd_start_d;
      shd_end_q   <= shd_end_d;
      shd_color_q <= shd_color_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_color_q <= act_color_d;
    end
  end

  assign shd_start = shd_start_q;
  assign shd_end   = shd_end_q;
  assign shd_color = shd_color_q;
  assign act_start = act_start_q;
  assign act_end   = act_end_q;
  assign act_color = act_color_q;

endmodule

// File: rtl/lda_avalon_slave.sv
// CPU-facing Avalon-MM slave for the line-draw engine: register decode,
// start/done handshake FSM and bus stall generation.
module lda_avalon_slave
  import lda_pkg::*;
#(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    s_address,
  input  logic          s_read,
  input  logic          s_write,
  input  logic [31:0]   s_writedata,
  output logic [31:0]   s_readdata,
  output logic          s_waitrequest,
  output logic          o_start,
  input  logic          i_done,
  output logic [XW-1:0] o_x0,
  output logic [YW-1:0] o_y0,
  output logic [XW-1:0] o_x1,
  output logic [YW-1:0] o_y1,
  output logic [CW-1:0] o_color
);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   start_q, start_d;

  logic busy, stall, wr_acc, go;
  logic wr_start, wr_end, wr_color;
  logic [31:0] rdata;

  logic [XW+YW-1:0] shd_start, shd_end, act_start, act_end;
  logic [CW-1:0]    shd_color;

  logic unused_wdata;
  assign unused_wdata = ^s_writedata[31:XW+YW];

  always_comb begin
    busy     = (state_q != ST_IDLE);
    stall    = !mode_q && busy && (s_read || s_write);
    wr_acc   = s_write && !stall;
    // GO only takes effect from IDLE; in poll mode a busy GO is silently dropped.
    go       = wr_acc && (s_address == ADDR_GO) && (state_q == ST_IDLE);
    wr_start = wr_acc && (s_address == ADDR_START);
    wr_end   = wr_acc && (s_address == ADDR_END);
    wr_color = wr_acc && (s_address == ADDR_COLOR);

    mode_d = (wr_acc && (s_address == ADDR_MODE)) ? s_writedata[0] : mode_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (i_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_ISSUE);

    rdata = '0;
    case (s_address)
      ADDR_MODE:   rdata[0] = mode_q;
      ADDR_STATUS: rdata[0] = busy;
      ADDR_START:  rdata[XW+YW-1:0] = shd_start;
      ADDR_END:    rdata[XW+YW-1:0] = shd_end;
      ADDR_COLOR:  rdata[CW-1:0] = shd_color;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
    end
  end

  lda_cmd_regs #(
    .XW(XW),
    .YW(YW),
    .CW(CW)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .wr_start  (wr_start),
    .wr_end    (wr_end),
    .wr_color  (wr_color),
    .wdata     (s_writedata[XW+YW-1:0]),
    .latch     (go),
    .shd_start (shd_start),
    .shd_end   (shd_end),
    .shd_color (shd_color),
    .act_start (act_start),
    .act_end   (act_end),
    .act_color (o_color)
  );

  assign s_readdata    = rdata;
  assign s_waitrequest = stall;
  assign o_start       = start_q;
  assign o_x0          = act_start[XW-1:0];
  assign o_y0          = act_start[XW+YW-1:XW];
  assign o_x1          = act_end[XW-1:0];
  assign o_y1          = act_end[XW+YW-1:XW];

endmodule
